// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for a single-ported synchronous memory, with bounded bus lock.
// Grant is combinational (0 cycles); read data returns 1 cycle after the strobe. A losing requester stalls via gnt=0.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4,
  parameter bit P0_FIRST = 1'b1
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          req0,
  input  logic          lock0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          lock1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  localparam int             CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]  LOCK_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  // With MAX_LOCK=1 a lock would expire in the same cycle it is taken.
  localparam bit             LOCK_EN  = (MAX_LOCK > 1);
  localparam logic           PRIO_RST = P0_FIRST ? 1'b0 : 1'b1;

  logic [1:0]    state_q, state_d;
  logic          prio_q, prio_d;      // 0: port 0 wins a tie, 1: port 1 wins
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_own_q, rd_own_d;

  logic          g0, g1;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 && (!req1 || !prio_q)) g0 = 1'b1;
        else if (req1)                  g1 = 1'b1;
      end
      S_OWN0:  g0 = req0;
      S_OWN1:  g1 = req1;
      default: ;
    endcase
  end

  assign gnt0 = g0 & ~rst;
  assign gnt1 = g1 & ~rst;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = lock_cnt_q + CNT_ONE;
    case (state_q)
      S_IDLE: begin
        if (gnt0) begin
          prio_d = 1'b1;
          if (lock0 && LOCK_EN) begin
            state_d    = S_OWN0;
            lock_cnt_d = CNT_ONE;
          end
        end else if (gnt1) begin
          prio_d = 1'b0;
          if (lock1 && LOCK_EN) begin
            state_d    = S_OWN1;
            lock_cnt_d = CNT_ONE;
          end
        end
      end
      S_OWN0: begin
        lock_cnt_d = cnt_inc;
        if ((gnt0 && !lock0) || (cnt_inc == LOCK_MAX)) begin
          state_d    = S_IDLE;
          prio_d     = 1'b1;
          lock_cnt_d = '0;
        end
      end
      S_OWN1: begin
        lock_cnt_d = cnt_inc;
        if ((gnt1 && !lock1) || (cnt_inc == LOCK_MAX)) begin
          state_d    = S_IDLE;
          prio_d     = 1'b0;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_ce    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
    rd_vld_d = mem_ce & ~mem_we;
    rd_own_d = gnt1;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prio_q     <= PRIO_RST;
      lock_cnt_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_own_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_own_q   <= rd_own_d;
    end
  end

  assign rvalid0 = rd_vld_q & ~rd_own_q;
  assign rvalid1 = rd_vld_q &  rd_own_q;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256x16 write-first memory model and a read-response scoreboard.
module tb_mem_port_arbiter;

  logic        ck;
  logic        rst;
  logic        req0, lock0, we0, gnt0, rvalid0;
  logic [7:0]  addr0;
  logic [15:0] wdata0, rdata0;
  logic        req1, lock1, we1, gnt1, rvalid1;
  logic [7:0]  addr1;
  logic [15:0] wdata1, rdata1;
  logic        mem_ce, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(8), .DW(16), .MAX_LOCK(4), .P0_FIRST(1'b1)) dut (
    .ck(ck), .rst(rst),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  logic [15:0] mem     [256];
  logic [15:0] exp_mem [256];

  always @(posedge ck) begin
    if (mem_ce) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    int          port;
    logic [15:0] data;
    int          due;
  } resp_t;

  resp_t rq[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag);
    logic        ev0, ev1;
    logic [15:0] ed0, ed1;
    resp_t       r;
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (rq.size() > 0 && rq[0].due == cyc_n) begin
      r = rq.pop_front();
      if (r.port == 0) begin ev0 = 1'b1; ed0 = r.data; end
      else             begin ev1 = 1'b1; ed1 = r.data; end
    end
    chk({tag, ":rvalid0"}, rvalid0, ev0);
    chk({tag, ":rvalid1"}, rvalid1, ev1);
    chk({tag, ":rdata0"},  rdata0,  ed0);
    chk({tag, ":rdata1"},  rdata1,  ed1);
  endtask

  // One clock: check grants/memory strobe and responses at the falling edge,
  // record what the expected winner does, then return just after the rising edge.
  task automatic cycle(input logic eg0, input logic eg1, input string tag);
    logic        ewe;
    logic [7:0]  ea;
    logic [15:0] ewd;
    ewe = 1'b0; ea = '0; ewd = '0;
    if (eg0)      begin ewe = we0; ea = addr0; ewd = wdata0; end
    else if (eg1) begin ewe = we1; ea = addr1; ewd = wdata1; end
    @(negedge ck);
    chk({tag, ":gnt0"},      gnt0,      eg0);
    chk({tag, ":gnt1"},      gnt1,      eg1);
    chk({tag, ":mem_ce"},    mem_ce,    eg0 | eg1);
    chk({tag, ":mem_we"},    mem_we,    ewe);
    chk({tag, ":mem_addr"},  mem_addr,  ea);
    chk({tag, ":mem_wdata"}, mem_wdata, ewd);
    check_resp(tag);
    if (eg0 || eg1) begin
      if (ewe) exp_mem[ea] = ewd;
      else     rq.push_back('{port: (eg0 ? 0 : 1), data: exp_mem[ea], due: cyc_n + 1});
    end
    @(posedge ck);
    #1;
    cyc_n++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'((i * 37) + 5);
      exp_mem[i] = 16'((i * 37) + 5);
    end
    mem[8'h10]     = 16'hBEEF;
    exp_mem[8'h10] = 16'hBEEF;

    rst = 1'b1;
    req0 = 1'b0; lock0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    cycle(1'b0, 1'b0, "reset");
    rst = 1'b0;
    cycle(1'b0, 1'b0, "idle");

    // Single port: three back-to-back reads of 0x10, then one port-1 read
    // (which also hands tie priority back to port 0).
    req0 = 1'b1; addr0 = 8'h10;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "single");
    req0 = 1'b0; req1 = 1'b1; addr1 = 8'h11;
    cycle(1'b0, 1'b1, "p1rd");

    // Contention: strict alternation starting with port 0.
    req0 = 1'b1; addr0 = 8'h30; addr1 = 8'h31;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, "cont0");
      cycle(1'b0, 1'b1, "cont1");
    end

    // Lock: port 0 takes one transfer, then port 1 does a locked two-word write.
    req1 = 1'b0; addr0 = 8'h40;
    cycle(1'b1, 1'b0, "pre_lock");
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 8'h20; wdata1 = 16'h1234; addr0 = 8'h41;
    cycle(1'b0, 1'b1, "lock_w1");
    lock1 = 1'b0; addr1 = 8'h21; wdata1 = 16'h5678;
    cycle(1'b0, 1'b1, "lock_w2");
    req1 = 1'b0; we1 = 1'b0; addr0 = 8'h20;
    cycle(1'b1, 1'b0, "after_lock");
    addr0 = 8'h21;
    cycle(1'b1, 1'b0, "rd_21");

    // Read-after-write to the same address on consecutive cycles.
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 8'h05; wdata1 = 16'hA5A5;
    cycle(1'b0, 1'b1, "raw_w");
    req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; addr0 = 8'h05;
    cycle(1'b1, 1'b0, "raw_r");
    req0 = 1'b0;
    cycle(1'b0, 1'b0, "raw_resp");

    // Lock timeout: give tie priority to port 0 first.
    req1 = 1'b1; addr1 = 8'h51;
    cycle(1'b0, 1'b1, "pre_to");
    req0 = 1'b1; lock0 = 1'b1; addr0 = 8'h50;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, "to_own");
    cycle(1'b0, 1'b1, "to_p1");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "to_resume");
    // Owner idles while holding the lock: port 1 stays stalled until it expires.
    req0 = 1'b0; lock0 = 1'b0;
    cycle(1'b0, 1'b0, "to_stall");
    cycle(1'b0, 1'b1, "to_expire");

    // Reset in the middle of a read: the response must be dropped.
    req1 = 1'b0; req0 = 1'b1; addr0 = 8'h10;
    cycle(1'b1, 1'b0, "rst_rd");
    rst = 1'b1; req1 = 1'b1;
    rq.delete();
    cycle(1'b0, 1'b0, "in_rst");
    rst = 1'b0;
    cycle(1'b1, 1'b0, "post_rst");
    req0 = 1'b0; req1 = 1'b0;
    cycle(1'b0, 1'b0, "post_rst_resp");
    cycle(1'b0, 1'b0, "drain");

    chk("sb_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
